// File: rtl/rom_fetch_pipe_if.sv
// Fetch-side bundle for the loadable instruction ROM: boot load port,
// flush, request and response handshakes. Names are from the ROM's viewpoint.
interface rom_fetch_pipe_if #(
  parameter int unsigned IDX_LEN  = 64,
  parameter int unsigned DATA_LEN = 32
);
  logic                load_start_i;
  logic                load_valid_i;
  logic [DATA_LEN-1:0] load_data_i;
  logic                load_done_o;
  logic                flush_i;
  logic                req_valid_i;
  logic                req_ready_o;
  logic [IDX_LEN-1:0]  req_idx_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DATA_LEN-1:0] rsp_data_o;
  logic                rsp_err_o;

  modport slave (
    input  load_start_i, load_valid_i, load_data_i, flush_i,
           req_valid_i, req_idx_i, rsp_ready_i,
    output load_done_o, req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output load_start_i, load_valid_i, load_data_i, flush_i,
           req_valid_i, req_idx_i, rsp_ready_i,
    input  load_done_o, req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/rom_fetch_pipe.sv
// Loadable instruction ROM for the fetch stage: sequential boot load, then
// byte-PC fetches through an RD_LAT-deep stallable, flushable read pipeline.
module rom_fetch_pipe #(
  parameter int unsigned        IDX_LEN    = 64,
  parameter logic [IDX_LEN-1:0] BASE_IDX   = IDX_LEN'(64'h0000_0000_8000_0000),
  parameter int unsigned        DATA_LEN   = 32,
  parameter int unsigned        ROM_DEPTH  = 32,
  parameter int unsigned        ROM_IDXLEN = 5,
  parameter int unsigned        RD_LAT     = 1
) (
  input  logic            clk,
  input  logic            rst,
  rom_fetch_pipe_if.slave bus
);

  localparam logic [IDX_LEN-1:0]    ROM_BYTES = IDX_LEN'(ROM_DEPTH * 4);
  localparam logic [ROM_IDXLEN-1:0] LAST_IDX  = ROM_IDXLEN'(ROM_DEPTH - 1);

  typedef enum logic {LOAD, SERVE} state_e;

  state_e                           state_q;
  logic [ROM_IDXLEN-1:0]            cnt_q;
  logic                             load_done_q;
  logic [DATA_LEN-1:0]              mem_q [ROM_DEPTH];

  logic [RD_LAT-1:0]                vld_pipe_q;
  logic [RD_LAT-1:0][DATA_LEN-1:0]  dat_pipe_q;
  logic [RD_LAT-1:0]                err_pipe_q;

  logic                  serve, stall, accept, addr_err;
  logic [IDX_LEN-1:0]    off;
  logic [ROM_IDXLEN-1:0] word;
  logic [DATA_LEN-1:0]   rd_data;

  assign serve    = (state_q == SERVE);
  assign stall    = vld_pipe_q[RD_LAT-1] && !bus.rsp_ready_i;
  assign accept   = bus.req_valid_i && bus.req_ready_o;

  // PCs below the base wrap to huge offsets and fault via the range check.
  assign off      = bus.req_idx_i - BASE_IDX;
  assign addr_err = (off[1:0] != 2'b00) || (off >= ROM_BYTES);
  assign word     = off[ROM_IDXLEN+1:2];
  assign rd_data  = addr_err ? '0 : mem_q[word];

  assign bus.req_ready_o = serve && !stall && !bus.flush_i && !bus.load_start_i;
  assign bus.load_done_o = load_done_q;
  assign bus.rsp_valid_o = vld_pipe_q[RD_LAT-1];
  assign bus.rsp_data_o  = dat_pipe_q[RD_LAT-1];
  assign bus.rsp_err_o   = err_pipe_q[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: if (bus.load_valid_i) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q     <= SERVE;
            load_done_q <= 1'b1;
          end
        end
        SERVE: if (bus.load_start_i) begin
          state_q     <= LOAD;
          cnt_q       <= '0;
          load_done_q <= 1'b0;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Contents survive reset; only the load port ever writes them.
  always_ff @(posedge clk) begin
    if (!rst && !serve && bus.load_valid_i)
      mem_q[cnt_q] <= bus.load_data_i;
  end

  // Data is read at accept time and carried down the stages; the array only
  // changes in LOAD, when no fetch can be in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      err_pipe_q <= '0;
    end else if ((serve && bus.load_start_i) || bus.flush_i) begin
      vld_pipe_q <= '0;
    end else if (!stall) begin
      vld_pipe_q[0] <= accept;
      dat_pipe_q[0] <= rd_data;
      err_pipe_q[0] <= addr_err;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        dat_pipe_q[i] <= dat_pipe_q[i-1];
        err_pipe_q[i] <= err_pipe_q[i-1];
      end
    end
  end

endmodule
